serial_sub8: RTL and testbench

SERIAL_SUB8 -- requirements
Module: serial_sub8

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/serial_sub_bit.sv | 16 +
 rtl/serial_sub8.sv | 122 ++++++++++++
 tb/tb_serial_sub8.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial two's complement subtractor.
package serial_sub_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_bit.sv
// One subtractor bit slice: s/cout of x + ~y + cin.
module serial_sub_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic y_inv;

  assign y_inv = ~y;
  assign s     = x ^ y_inv ^ cin;
  assign cout  = (x & y_inv) | (x & cin) | (y_inv & cin);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial signed subtractor d = a - b, LSB first, one bit per clock.
// Define SERIAL_SUB8_SATURATE_EN to clamp d on signed overflow.
module serial_sub8
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             over
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, r_sh_reg;
  logic             a_msb_reg, b_msb_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] d_reg;
  logic             over_reg;

  logic             bit_s, bit_cout;
  logic             load;
  logic             last_bit;
  logic [WIDTH-1:0] raw_d;
  logic             ovf;
  logic [WIDTH-1:0] d_final;

  serial_sub_bit u_bit (
    .x    (a_sh_reg[0]),
    .y    (b_sh_reg[0]),
    .cin  (carry_reg),
    .s    (bit_s),
    .cout (bit_cout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign load     = start && (state_reg != SHIFT);
  assign last_bit = (cnt_reg == LAST);
  // The final bit completes the result this edge, so fold it in before loading d.
  assign raw_d    = {bit_s, r_sh_reg[WIDTH-1:1]};
  assign ovf      = (a_msb_reg != b_msb_reg) && (raw_d[WIDTH-1] != a_msb_reg);

`ifdef SERIAL_SUB8_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  assign d_final = ovf ? (a_msb_reg ? SAT_NEG : SAT_POS) : raw_d;
`else
  assign d_final = raw_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      r_sh_reg  <= '0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      d_reg     <= '0;
      over_reg  <= 1'b0;
    end else if (load) begin
      a_sh_reg  <= a;
      b_sh_reg  <= b;
      a_msb_reg <= a[WIDTH-1];
      b_msb_reg <= b[WIDTH-1];
      carry_reg <= 1'b1;
      cnt_reg   <= '0;
    end else if (state_reg == SHIFT) begin
      a_sh_reg  <= a_sh_reg >> 1;
      b_sh_reg  <= b_sh_reg >> 1;
      r_sh_reg  <= raw_d;
      carry_reg <= bit_cout;
      cnt_reg   <= cnt_reg + 1'b1;
      if (last_bit) begin
        d_reg    <= d_final;
        over_reg <= ovf;
      end
    end
  end

  assign d    = d_reg;
  assign over = over_reg;

endmodule

// File: tb/tb_serial_sub8.sv
// Scoreboard bench for serial_sub8: driver queues expectations, monitor checks each done pulse.
module tb_serial_sub8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, over;
  logic [W-1:0] d;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         over;
    int           e0;
  } exp_t;

  exp_t sb[$];

  serial_sub8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .over  (over)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Call right after a negedge; E0 is the next posedge.
  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic [W-1:0] ed, input logic eo, input bit expect_done);
    exp_t e;
    a = ai;
    b = bi;
    start = 1'b1;
    if (expect_done) begin
      e.d = ed; e.over = eo; e.e0 = cyc + 1;
      sb.push_back(e);
    end
    $display("issue a=0x%02h b=0x%02h", ai, bi);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("done d=0x%02h over=%0b (expect d=0x%02h over=%0b)", d, over, e.d, e.over);
        chk("d", 32'(d), 32'(e.d));
        chk("over", 32'(over), 32'(e.over));
        chk("latency", 32'(cyc - e.e0), 32'd8);
      end
    end
  end

  initial begin
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_over", 32'(over), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(8'h32, 8'h6F, 8'hC3, 1'b0, 1'b1);
    @(negedge clk);
    chk("busy_after_e0", 32'(busy), 32'd1);
    wait_done("op1");

    @(negedge clk);
`ifdef SERIAL_SUB8_SATURATE_EN
    issue(8'h80, 8'h01, 8'h80, 1'b1, 1'b1);
`else
    issue(8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
`endif
    wait_done("op2");

    @(negedge clk);
`ifdef SERIAL_SUB8_SATURATE_EN
    issue(8'h7F, 8'hFF, 8'h7F, 1'b1, 1'b1);
`else
    issue(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
`endif
    wait_done("op3");

    // Back-to-back: start held during the DONE cycle
    @(negedge clk);
    issue(8'hB2, 8'hB2, 8'h00, 1'b0, 1'b1);
    wait_done("op4");
    issue(8'h03, 8'hAF, 8'h54, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done("op5");

    // Start pulsed mid-SHIFT must be ignored
    @(negedge clk);
    issue(8'h10, 8'h01, 8'h0F, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    a = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("d_stable_shift", 32'(d), 32'h54);
    chk("busy_shift", 32'(busy), 32'd1);
    wait_done("op6");

    // Reset mid-SHIFT abandons the operation
    @(negedge clk);
    issue(8'h22, 8'h11, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_d", 32'(d), 32'd0);
    chk("midrst_over", 32'(over), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    issue(8'h05, 8'h07, 8'hFE, 1'b0, 1'b1);
    wait_done("op7");

    repeat (12) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
